// File: rtl/cordic_fp_pkg.sv
// Shared constants and types for the CORDIC fixed-point to IEEE-754 float path.
package cordic_fp_pkg;

  localparam int FIX_W   = 22;
  localparam int FRAC_W  = 20;
  localparam int FP_BIAS = 127;

  // Exponent when mag[21] is already set: weight of bit 21 is 2^(FIX_W-1-FRAC_W).
  localparam logic [7:0]  EXP_TOP     = 8'(FP_BIAS + FIX_W - 1 - FRAC_W);
  localparam logic [4:0]  MAX_SHIFT   = 5'(FIX_W - 1);
  localparam logic [31:0] FP_POS_ZERO = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_NORM = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/cordic_fix2float.sv
// Converts signed Q1.20 CORDIC output to single-precision float by shifting
// the magnitude left one bit per cycle until its top bit is set.
module cordic_fix2float
  import cordic_fp_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic [FIX_W-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [31:0]      out_data,
  output logic             out_valid,
  input  logic             out_ready
);

  state_e            state_q, state_d;
  logic              sign_q, sign_d;
  logic [FIX_W-1:0]  mag_q, mag_d;
  logic [4:0]        cnt_q, cnt_d;
  logic [31:0]       out_q, out_d;

  always_comb begin
    state_d = state_q;
    sign_d  = sign_q;
    mag_d   = mag_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          sign_d  = in_data[FIX_W-1];
          // -0x200000 wraps back to 0x200000, which is the correct unsigned magnitude.
          mag_d   = in_data[FIX_W-1] ? (~in_data + 1'b1) : in_data;
          cnt_d   = '0;
          state_d = ST_NORM;
        end
      end
      ST_NORM: begin
        if (mag_q[FIX_W-1]) begin
          out_d   = {sign_q, EXP_TOP - {3'b000, cnt_q}, mag_q[FIX_W-2:0], 2'b00};
          state_d = ST_DONE;
        end else if (cnt_q == MAX_SHIFT) begin
          // Only a zero magnitude can reach the shift limit without normalising.
          out_d   = FP_POS_ZERO;
          state_d = ST_DONE;
        end else begin
          mag_d = {mag_q[FIX_W-2:0], 1'b0};
          cnt_d = cnt_q + 5'd1;
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      sign_q  <= 1'b0;
      mag_q   <= '0;
      cnt_q   <= '0;
      out_q   <= FP_POS_ZERO;
    end else begin
      state_q <= state_d;
      sign_q  <= sign_d;
      mag_q   <= mag_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign out_data  = out_q;

endmodule

// File: doc/cordic_fix2float.md
CORDIC_FIX2FLOAT -- requirements
Module: cordic_fix2float

Interface
REQ-001 Parameters: none; widths are fixed (22-bit input, 32-bit output).
REQ-002 clk  input  1  clock; all state updates on the rising edge.
REQ-003 reset  input  1  reset, synchronous, active-high; clock clk.
REQ-004 in_data  input  22  signed two's-complement fixed point, 20 fractional bits; value = in_data / 2^20 (CORDIC cos_out format).
REQ-005 in_valid  input  1  in_data is valid this cycle.
REQ-006 in_ready  output  1  block can accept; high only in IDLE.
REQ-007 out_data  output  32  IEEE-754 single-precision result.
REQ-008 out_valid  output  1  out_data is valid; held until accepted.
REQ-009 out_ready  input  1  consumer accepts out_data this cycle.

Function
REQ-010 Accept occurs on an edge where in_valid && in_ready; inputs are ignored at all other times.
REQ-011 On accept, the block SHALL register sign = in_data[21] and mag = |in_data| as a 22-bit unsigned value (0x200000 gives mag 0x200000, weight 2.0), clear shift count cnt (5 bits), and enter NORM.
REQ-012 States: IDLE, NORM, DONE; no other states are reachable.
REQ-013 NORM, mag == 0: register out_data = 0x00000000 (positive zero, sign discarded) and go to DONE.
REQ-014 NORM, mag[21] == 1: register out_data = {sign, exp, mant} and go to DONE, where exp = 128 - cnt (8 bits) and mant = {mag[20:0], 2'b00}.
REQ-015 NORM, otherwise: mag <= mag << 1, cnt <= cnt + 1, and stay in NORM; cnt never exceeds 21.
REQ-016 The conversion is exact with no rounding, since at most 21 significant bits go into a 23-bit mantissa; exp stays within 107..128.
REQ-017 DONE: out_valid = 1 and out_data is stable; on out_ready go to IDLE, where out_valid = 0 on the next cycle.
REQ-018 in_ready is low in NORM and DONE, so a new input cannot be accepted in the same cycle that an output is accepted.
REQ-019 Latency from the accept edge to out_valid high = cnt + 2 edges, where cnt = leading-zero count of mag within 22 bits; this is 2 minimum and 23 maximum (zero input: 23).
REQ-020 in_data is not required to be held after the accept edge.
REQ-021 A held in_valid level is treated as one request per IDLE visit, which is compatible with the level-type CORDIC done signal.

Reset
REQ-022 While reset is high at an edge: state = IDLE, out_valid = 0, out_data = 0x00000000, mag = 0, cnt = 0, sign = 0.
REQ-023 Reset asserted in NORM or DONE SHALL abort the in-flight conversion with no output produced.
REQ-024 Reset has priority over accept and over out_ready in the same cycle.
REQ-025 in_ready SHALL be high in the first cycle after reset deasserts.

Structure
REQ-026 Shared package cordic_fp_pkg SHALL hold FIX_W=22, FRAC_W=20, FP_BIAS=127, the state enum (IDLE/NORM/DONE), and the positive-zero constant.
REQ-027 The block is a single module with no sub-module; the one-bit-per-cycle shifter makes a separate leading-zero counter unnecessary.
REQ-028 The block sits directly downstream of the CORDIC core: in_data connects to cos_out and in_valid connects to done.

Verification
REQ-029 in_data 0x100000 (1.0) -> out_data 0x3F800000; out_valid rises 3 edges after accept.
REQ-030 in_data 0x09B74E (CORDIC gain init, ~0.60725) -> out_data 0x3F1B74E0; latency 4.
REQ-031 in_data 0x300000 (-1.0) -> 0xBF800000; in_data 0x200000 (-2.0) -> 0xC0000000 with latency 2.
REQ-032 in_data 0x000000 -> 0x00000000 with latency 23; in_data 0x000001 -> 0x35800000 with latency 23.
REQ-033 Backpressure: hold out_ready = 0 for 10 cycles -> out_valid and out_data stable and in_ready low throughout; pulse out_ready -> next cycle in IDLE with in_ready = 1.
REQ-034 Reset during NORM while converting 0x000001 -> next cycle IDLE with out_valid = 0; the next input, 0x100000, yields 0x3F800000 only.
